// File: rtl/math_peak_34_if.sv
// Stream and result bundle for the windowed peak search.
// The master drives the sample stream; the slave is the peak-search core.
interface math_peak_34_if #(
  parameter int IW = 6
) ();
  logic              start;
  logic [33:0]       din;
  logic              din_vld;
  logic              busy;
  logic              dout_vld;
  logic [33:0]       peak;
  logic [IW-1:0]     peak_idx;
  logic [33+IW:0]    sum;

  modport master (
    output start, din, din_vld,
    input  busy, dout_vld, peak, peak_idx, sum
  );

  modport slave (
    input  start, din, din_vld,
    output busy, dout_vld, peak, peak_idx, sum
  );
endinterface

// File: rtl/math_peak_34.sv
// Windowed peak search: max, index of max and sum over 2^IW accepted magnitudes.
// Results register one ena-cycle after the last sample of a window.
module math_peak_34 #(
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  math_peak_34_if.slave bus
);
  localparam int SW = 34 + IW;
  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_ACC  = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [33:0]   run_max_q, run_max_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic [SW-1:0] run_sum_q, run_sum_d;
  logic [33:0]   peak_q, peak_d;
  logic [IW-1:0] peak_idx_q, peak_idx_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          dout_vld_q, dout_vld_d;

  logic          take_max;
  logic          last_sample;
  logic [33:0]   acc_max;
  logic [IW-1:0] acc_idx;
  logic [SW-1:0] acc_sum;

  always_comb begin
    // First sample of a window always loads; afterwards only a strict increase does.
    take_max    = (cnt_q == '0) || (bus.din > run_max_q);
    acc_max     = take_max ? bus.din : run_max_q;
    acc_idx     = take_max ? cnt_q : run_idx_q;
    acc_sum     = run_sum_q + SW'(bus.din);
    last_sample = (state_q == S_ACC) && bus.din_vld && (cnt_q == LAST_IDX);

    state_d    = state_q;
    cnt_d      = cnt_q;
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    run_sum_d  = run_sum_q;
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    sum_d      = sum_q;
    dout_vld_d = 1'b0;

    if (last_sample) begin
      // A start coinciding with the last sample opens an empty fresh window.
      peak_d     = acc_max;
      peak_idx_d = acc_idx;
      sum_d      = acc_sum;
      dout_vld_d = 1'b1;
      state_d    = bus.start ? S_ACC : S_IDLE;
      cnt_d      = '0;
      run_max_d  = '0;
      run_idx_d  = '0;
      run_sum_d  = '0;
    end else if (bus.start) begin
      state_d   = S_ACC;
      run_idx_d = '0;
      if (bus.din_vld) begin
        cnt_d     = IW'(1);
        run_max_d = bus.din;
        run_sum_d = SW'(bus.din);
      end else begin
        cnt_d     = '0;
        run_max_d = '0;
        run_sum_d = '0;
      end
    end else if ((state_q == S_ACC) && bus.din_vld) begin
      cnt_d     = cnt_q + IW'(1);
      run_max_d = acc_max;
      run_idx_d = acc_idx;
      run_sum_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      run_sum_q  <= '0;
      peak_q     <= '0;
      peak_idx_q <= '0;
      sum_q      <= '0;
      dout_vld_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_max_q  <= run_max_d;
      run_idx_q  <= run_idx_d;
      run_sum_q  <= run_sum_d;
      peak_q     <= peak_d;
      peak_idx_q <= peak_idx_d;
      sum_q      <= sum_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign bus.busy     = (state_q == S_ACC);
  assign bus.dout_vld = dout_vld_q;
  assign bus.peak     = peak_q;
  assign bus.peak_idx = peak_idx_q;
  assign bus.sum      = sum_q;
endmodule

// File: tb/tb_math_peak_34.sv
// Directed bench for math_peak_34: one IW=2 instance and one IW=6 instance.
module tb_math_peak_34;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses2 = 0;
  int   base;

  localparam logic [33:0] MAXV = 34'h3_FFFF_FFFF;

  math_peak_34_if #(.IW(2)) if2 ();
  math_peak_34_if #(.IW(6)) if6 ();

  math_peak_34 #(.IW(2)) u2 (.clk(clk), .rst(rst), .ena(ena), .bus(if2.slave));
  math_peak_34 #(.IW(6)) u6 (.clk(clk), .rst(rst), .ena(ena), .bus(if6.slave));

  always #5 clk = ~clk;

  // Result strobes that land on an enabled cycle.
  always @(posedge clk) if (ena && if2.dout_vld) pulses2++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic d2(input logic s, input logic v, input logic [33:0] x);
    if2.start   = s;
    if2.din_vld = v;
    if2.din     = x;
    tick();
  endtask

  task automatic chk_res2(input string tag, input logic [33:0] p, input logic [1:0] i, input logic [35:0] s);
    chk({tag, ".dout_vld"}, if2.dout_vld, 1'b1);
    chk({tag, ".peak"},     if2.peak, p);
    chk({tag, ".peak_idx"}, if2.peak_idx, i);
    chk({tag, ".sum"},      if2.sum, s);
  endtask

  initial begin
    if2.start = 0; if2.din_vld = 0; if2.din = '0;
    if6.start = 0; if6.din_vld = 0; if6.din = '0;

    // Reset state
    rst = 1; tick(); tick();
    chk("rst.busy2", if2.busy, 1'b0);
    chk("rst.dout2", if2.dout_vld, 1'b0);
    chk("rst.peak2", if2.peak, 34'd0);
    chk("rst.sum6",  if6.sum, 40'd0);
    rst = 0;

    // Basic window 5,9,3,7
    d2(1, 1, 5);
    chk("t1.busy_rise", if2.busy, 1'b1);
    chk("t1.dout_early", if2.dout_vld, 1'b0);
    d2(0, 1, 9); d2(0, 1, 3); d2(0, 1, 7);
    chk_res2("t1", 9, 1, 24);
    chk("t1.busy_fall", if2.busy, 1'b0);
    d2(0, 0, 0);
    chk("t1.dout_drop", if2.dout_vld, 1'b0);
    chk("t1.busy_idle", if2.busy, 1'b0);

    // Tie keeps earliest index
    d2(1, 1, 4); d2(0, 1, 8); d2(0, 1, 8); d2(0, 1, 2);
    chk_res2("t2", 8, 1, 22);
    d2(0, 0, 0);

    // All-max IW=6 window
    if6.start = 1; if6.din_vld = 1; if6.din = MAXV;
    for (int i = 0; i < 64; i++) begin
      tick();
      if6.start = 0;
      if (i == 62) chk("t3.dout_early", if6.dout_vld, 1'b0);
    end
    chk("t3.dout_vld", if6.dout_vld, 1'b1);
    chk("t3.peak", if6.peak, MAXV);
    chk("t3.peak_idx", if6.peak_idx, 6'd0);
    chk("t3.sum", if6.sum, 40'hFF_FFFF_FFC0);
    chk("t3.busy", if6.busy, 1'b0);
    if6.din_vld = 0; tick();

    // Gaps in din_vld and ena held low mid-window
    base = pulses2;
    d2(1, 1, 5); d2(0, 0, 0); d2(0, 1, 9);
    ena = 0;
    d2(0, 1, 100); d2(1, 1, 100); d2(0, 1, 100);
    ena = 1;
    d2(0, 1, 3);
    chk("t4.dout_early", if2.dout_vld, 1'b0);
    d2(0, 1, 7);
    chk_res2("t4", 9, 1, 24);
    ena = 0;
    d2(0, 1, 100);
    chk("t4.dout_hold", if2.dout_vld, 1'b1);
    ena = 1;
    d2(0, 0, 0);
    chk("t4.dout_drop", if2.dout_vld, 1'b0);
    chk("t4.pulses", pulses2 - base, 1);

    // Abort and restart
    base = pulses2;
    d2(1, 1, 100); d2(0, 1, 200);
    d2(1, 1, 1); d2(0, 1, 2); d2(0, 1, 3);
    chk("t5.dout_early", if2.dout_vld, 1'b0);
    d2(0, 1, 4);
    chk_res2("t5", 4, 3, 10);
    d2(0, 0, 0);
    chk("t5.pulses", pulses2 - base, 1);

    // Reset mid-window
    d2(1, 1, 5); d2(0, 1, 9);
    rst = 1; d2(0, 0, 0); rst = 0;
    chk("t6.busy", if2.busy, 1'b0);
    chk("t6.dout", if2.dout_vld, 1'b0);
    chk("t6.peak", if2.peak, 34'd0);
    chk("t6.peak_idx", if2.peak_idx, 2'd0);
    chk("t6.sum", if2.sum, 36'd0);
    base = pulses2;
    d2(0, 1, 50); d2(0, 1, 50); d2(0, 1, 50); d2(0, 1, 50); d2(0, 0, 0);
    chk("t6.idle_busy", if2.busy, 1'b0);
    chk("t6.pulses", pulses2 - base, 0);

    // Back-to-back windows
    d2(1, 1, 3); d2(0, 1, 1); d2(0, 1, 1); d2(1, 1, 1);
    chk_res2("t7a", 3, 0, 6);
    chk("t7a.busy", if2.busy, 1'b1);
    d2(0, 1, 2);
    chk("t7.gap1", if2.dout_vld, 1'b0);
    d2(0, 1, 6);
    chk("t7.gap2", if2.dout_vld, 1'b0);
    d2(0, 1, 6);
    chk("t7.gap3", if2.dout_vld, 1'b0);
    d2(0, 1, 0);
    chk_res2("t7b", 6, 1, 14);
    chk("t7b.busy", if2.busy, 1'b0);
    d2(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
